// File: rtl/whack_sequencer.sv
// whack_sequencer
// Game controller for a five-circle whack-a-mole. Picks which circle is lit,
// times each appearance, scores hits on the lit circle and takes a life on a
// wrong press or a timeout. The visible window shrinks as the score grows.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, honoured only in IDLE and OVER
//   btn[4:0]   one-cycle press pulses, bit i = circle i
//   active     one-hot lit circle, or 0
//   hit_flash  one-hot circle flashing after a hit, or 0
//   score      hit count, saturating at 255
//   lives      remaining lives
//   game_over  high in OVER
//   busy       high in GAP, SHOW or HIT
module whack_sequencer #(
   parameter int unsigned SHOW_CYCLES  = 50_000_000,
   parameter int unsigned SHOW_MIN     = 15_000_000,
   parameter int unsigned SHOW_STEP    = 2_500_000,
   parameter int unsigned GAP_CYCLES   = 25_000_000,
   parameter int unsigned FLASH_CYCLES = 10_000_000,
   parameter int unsigned LIVES        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] btn,
   output logic [4:0] active,
   output logic [4:0] hit_flash,
   output logic [7:0] score,
   output logic [2:0] lives,
   output logic       game_over,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_GAP, S_SHOW, S_HIT, S_MISS, S_OVER
   } state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [7:0]  lfsr;
   logic [2:0]  prev;

   logic        fb;
   logic [2:0]  r;
   logic [2:0]  idx;
   logic [4:0]  onehot;
   logic [31:0] dec;
   logic [32:0] lim;
   logic [31:0] win;

   assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   // Fold 5..7 onto 0..2, then step past the previous circle so the same
   // circle never lights twice in a row.
   always_comb begin
      r   = lfsr[2:0];
      idx = 3'd0;
      if (r > 3'd4) r = r - 3'd5;
      if (r == prev) idx = (r == 3'd4) ? 3'd0 : r + 3'd1;
      else           idx = r;
   end

   assign onehot = 5'b00001 << idx;

   // Clamp is decided on dec + SHOW_MIN (33 bits) so the subtraction below
   // is only ever taken when it cannot underflow past the floor.
   assign dec = 32'(score[7:2]) * SHOW_STEP;
   assign lim = {1'b0, dec} + {1'b0, SHOW_MIN};
   assign win = (lim >= {1'b0, SHOW_CYCLES}) ? SHOW_MIN : SHOW_CYCLES - dec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         lfsr      <= 8'hA5;
         prev      <= 3'd0;
         active    <= '0;
         hit_flash <= '0;
         score     <= '0;
         lives     <= 3'(LIVES);
         game_over <= 1'b0;
         busy      <= 1'b0;
      end else begin
         lfsr <= {lfsr[6:0], fb};
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_GAP;
                  cnt   <= GAP_CYCLES;
                  busy  <= 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == 32'd1) begin
                  state  <= S_SHOW;
                  active <= onehot;
                  prev   <= idx;
                  cnt    <= win;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            S_SHOW: begin
               // A press on the lit circle wins over stray bits and timeout.
               if ((btn & active) != 5'd0) begin
                  state     <= S_HIT;
                  score     <= (score == 8'hFF) ? score : score + 8'd1;
                  hit_flash <= active;
                  active    <= '0;
                  cnt       <= FLASH_CYCLES;
               end else if (btn != 5'd0 || cnt == 32'd1) begin
                  state  <= S_MISS;
                  active <= '0;
                  lives  <= lives - 3'd1;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            S_HIT: begin
               if (cnt == 32'd1) begin
                  state     <= S_GAP;
                  hit_flash <= '0;
                  cnt       <= GAP_CYCLES;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            S_MISS: begin
               if (lives == 3'd0) begin
                  state     <= S_OVER;
                  game_over <= 1'b1;
               end else begin
                  state <= S_GAP;
                  cnt   <= GAP_CYCLES;
                  busy  <= 1'b1;
               end
            end
            S_OVER: begin
               active <= '0;
               if (start) begin
                  state     <= S_GAP;
                  cnt       <= GAP_CYCLES;
                  score     <= '0;
                  lives     <= 3'(LIVES);
                  game_over <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
